// File: rtl/alien_hit_detector_if.sv
// Bullet request/response bundle between the bullet logic and the hit detector.
// The request fields are sampled only while Busy is low.
interface alien_hit_detector_if;
    logic       BulletValid;
    logic [8:0] BulletRow;
    logic [9:0] BulletCol;
    logic       Busy;
    logic       BulletDone;
    logic       BulletHit;
    logic [2:0] HitRow;
    logic [3:0] HitCol;
    logic [5:0] ScoreInc;

    modport master (
        output BulletValid, BulletRow, BulletCol,
        input  Busy, BulletDone, BulletHit, HitRow, HitCol, ScoreInc
    );

    modport slave (
        input  BulletValid, BulletRow, BulletCol,
        output Busy, BulletDone, BulletHit, HitRow, HitCol, ScoreInc
    );
endinterface

// File: rtl/alien_hit_detector.sv
// Tracks the alive state of the 5x10 alien formation and resolves bullets against it.
// Cell indices come from repeated subtraction of the cell pitch, so no divider is needed.
module alien_hit_detector #(
    parameter int CellW   = 39,
    parameter int CellH   = 24,
    parameter int SpriteW = 30,
    parameter int SpriteH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [8:0]           AliensRow,
    input  logic [9:0]           AliensCol,
    input  logic                 WaveReset,
    alien_hit_detector_if.slave  bus,
    output logic [49:0]          AliveMask,
    output logic [5:0]           AliveCount,
    output logic                 AllDead
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIV_COL = 2'd1;
    localparam logic [1:0] DIV_ROW = 2'd2;
    localparam logic [1:0] RESOLVE = 2'd3;

    logic [1:0]  state;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic [3:0]  col;
    logic [2:0]  row;
    logic        miss;

    logic [10:0] dxCap;
    logic [9:0]  dyCap;
    logic [5:0]  cellIdx;
    logic        kill;
    logic [5:0]  points;

    // Offsets are captured once; the MSB of each difference is its sign.
    assign dxCap   = {1'b0, bus.BulletCol} - {1'b0, AliensCol};
    assign dyCap   = {1'b0, bus.BulletRow} - {1'b0, AliensRow};
    assign cellIdx = 6'(row) * 6'd10 + 6'(col);
    assign kill    = !miss && (dx < 11'(SpriteW)) && (dy < 10'(SpriteH)) && AliveMask[cellIdx];
    assign points  = (row == 3'd0) ? 6'd30 : (row <= 3'd2) ? 6'd20 : 6'd10;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            dx             <= '0;
            dy             <= '0;
            col            <= '0;
            row            <= '0;
            miss           <= 1'b0;
            AliveMask      <= '1;
            AliveCount     <= 6'd50;
            AllDead        <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.BulletDone <= 1'b0;
            bus.BulletHit  <= 1'b0;
            bus.HitRow     <= '0;
            bus.HitCol     <= '0;
            bus.ScoreInc   <= '0;
        end else begin
            bus.BulletDone <= 1'b0;
            bus.BulletHit  <= 1'b0;
            bus.ScoreInc   <= '0;
            if (WaveReset) begin
                // New wave wins over any in-flight check and any new request.
                state      <= IDLE;
                bus.Busy   <= 1'b0;
                AliveMask  <= '1;
                AliveCount <= 6'd50;
                AllDead    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.BulletValid) begin
                            dx       <= dxCap;
                            dy       <= dyCap;
                            col      <= '0;
                            row      <= '0;
                            bus.Busy <= 1'b1;
                            if (dxCap[10] || dyCap[9]) begin
                                miss  <= 1'b1;
                                state <= RESOLVE;
                            end else begin
                                miss  <= 1'b0;
                                state <= DIV_COL;
                            end
                        end
                    end
                    DIV_COL: begin
                        if (dx >= 11'(CellW)) begin
                            if (col == 4'd9) begin
                                miss  <= 1'b1;
                                state <= RESOLVE;
                            end else begin
                                dx  <= dx - 11'(CellW);
                                col <= col + 4'd1;
                            end
                        end else begin
                            state <= DIV_ROW;
                        end
                    end
                    DIV_ROW: begin
                        if (dy >= 10'(CellH)) begin
                            if (row == 3'd4) begin
                                miss  <= 1'b1;
                                state <= RESOLVE;
                            end else begin
                                dy  <= dy - 10'(CellH);
                                row <= row + 3'd1;
                            end
                        end else begin
                            state <= RESOLVE;
                        end
                    end
                    default: begin
                        if (kill) begin
                            AliveMask[cellIdx] <= 1'b0;
                            AliveCount         <= AliveCount - 6'd1;
                            AllDead            <= (AliveCount == 6'd1);
                            bus.BulletHit      <= 1'b1;
                            bus.HitRow         <= row;
                            bus.HitCol         <= col;
                            bus.ScoreInc       <= points;
                        end
                        bus.BulletDone <= 1'b1;
                        bus.Busy       <= 1'b0;
                        state          <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector: hit/miss timing, kill-all, wave reset and abort cases.
module tb_alien_hit_detector;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [8:0]  AliensRow = '0;
    logic [9:0]  AliensCol = 10'd10;
    logic        WaveReset = 1'b0;
    logic [49:0] AliveMask;
    logic [5:0]  AliveCount;
    logic        AllDead;
    int          total = 0;
    int          bad = 0;

    alien_hit_detector_if bus();

    alien_hit_detector dut (
        .Clk(Clk), .Reset(Reset), .AliensRow(AliensRow), .AliensCol(AliensCol),
        .WaveReset(WaveReset), .bus(bus),
        .AliveMask(AliveMask), .AliveCount(AliveCount), .AllDead(AllDead)
    );

    always #5 Clk = ~Clk;

    // Edge 0 is the posedge that samples the request; e is the edge of BulletDone, -1 on timeout.
    task automatic shoot(input logic [8:0] r, input logic [9:0] c, output int e);
        @(negedge Clk);
        bus.BulletValid = 1'b1; bus.BulletRow = r; bus.BulletCol = c;
        @(posedge Clk);
        @(negedge Clk);
        bus.BulletValid = 1'b0;
        e = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (bus.BulletDone) begin e = n; break; end
        end
    endtask

    task automatic test_reset();
        bus.BulletValid = 1'b0; bus.BulletRow = '0; bus.BulletCol = '0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        total++; if (AliveMask !== {50{1'b1}}) begin bad++; $display("FAIL reset_mask got=%h want=all ones", AliveMask); end
        total++; if (AliveCount !== 6'd50) begin bad++; $display("FAIL reset_count got=%0d want=50", AliveCount); end
        total++; if ({AllDead, bus.Busy, bus.BulletDone, bus.BulletHit} !== 4'b0)
            begin bad++; $display("FAIL reset_flags got=%b want=0000", {AllDead, bus.Busy, bus.BulletDone, bus.BulletHit}); end
        total++; if ({bus.HitRow, bus.HitCol, bus.ScoreInc} !== 13'd0)
            begin bad++; $display("FAIL reset_hitinfo got=%h want=0", {bus.HitRow, bus.HitCol, bus.ScoreInc}); end
    endtask

    task automatic test_hit();
        int e;
        AliensRow = 9'd0; AliensCol = 10'd10;
        shoot(9'd27, 10'd93, e);
        total++; if (e !== 6 || bus.BulletHit !== 1'b1 || bus.Busy !== 1'b0)
            begin bad++; $display("FAIL hit_timing got edge=%0d hit=%b busy=%b want edge=6 hit=1 busy=0", e, bus.BulletHit, bus.Busy); end
        total++; if (bus.HitRow !== 3'd1 || bus.HitCol !== 4'd2 || bus.ScoreInc !== 6'd20)
            begin bad++; $display("FAIL hit_info got r=%0d c=%0d s=%0d want r=1 c=2 s=20", bus.HitRow, bus.HitCol, bus.ScoreInc); end
        total++; if (AliveMask[12] !== 1'b0 || AliveCount !== 6'd49)
            begin bad++; $display("FAIL hit_mask got bit12=%b count=%0d want bit12=0 count=49", AliveMask[12], AliveCount); end
    endtask

    task automatic test_dead_and_negative();
        int e;
        shoot(9'd27, 10'd93, e);
        total++; if (e !== 6 || bus.BulletHit !== 1'b0 || bus.ScoreInc !== 6'd0 || AliveCount !== 6'd49)
            begin bad++; $display("FAIL dead_alien got edge=%0d hit=%b s=%0d count=%0d want 6/0/0/49", e, bus.BulletHit, bus.ScoreInc, AliveCount); end
        AliensRow = 9'd8; AliensCol = 10'd10;
        shoot(9'd3, 10'd5, e);
        total++; if (e !== 1 || bus.BulletHit !== 1'b0)
            begin bad++; $display("FAIL neg_both got edge=%0d hit=%b want edge=1 hit=0", e, bus.BulletHit); end
        shoot(9'd5, 10'd10, e);
        total++; if (e !== 1 || bus.BulletHit !== 1'b0)
            begin bad++; $display("FAIL neg_dy got edge=%0d hit=%b want edge=1 hit=0", e, bus.BulletHit); end
        AliensRow = 9'd0; AliensCol = 10'd10;
    endtask

    task automatic test_gap_overflow();
        int e;
        shoot(9'd5, 10'd45, e);
        total++; if (e !== 3 || bus.BulletHit !== 1'b0)
            begin bad++; $display("FAIL gap_miss got edge=%0d hit=%b want edge=3 hit=0", e, bus.BulletHit); end
        shoot(9'd5, 10'd400, e);
        total++; if (e !== 11 || bus.BulletHit !== 1'b0)
            begin bad++; $display("FAIL col_overflow got edge=%0d hit=%b want edge=11 hit=0", e, bus.BulletHit); end
        shoot(9'd130, 10'd10, e);
        total++; if (e !== 7 || bus.BulletHit !== 1'b0)
            begin bad++; $display("FAIL row_overflow got edge=%0d hit=%b want edge=7 hit=0", e, bus.BulletHit); end
        total++; if (AliveCount !== 6'd49)
            begin bad++; $display("FAIL miss_count got=%0d want=49", AliveCount); end
    endtask

    task automatic pulse_wave();
        @(negedge Clk); WaveReset = 1'b1;
        @(negedge Clk); WaveReset = 1'b0;
    endtask

    task automatic test_kill_all();
        int e;
        logic [5:0] sc;
        pulse_wave();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                shoot(9'(r * 24 + 2), 10'(10 + c * 39 + 3), e);
                sc = (r == 0) ? 6'd30 : (r < 3) ? 6'd20 : 6'd10;
                total++;
                if (e !== c + r + 3 || bus.BulletHit !== 1'b1 || bus.HitRow !== 3'(r) || bus.HitCol !== 4'(c) ||
                    bus.ScoreInc !== sc || AliveCount !== 6'(49 - (r * 10 + c))) begin
                    bad++;
                    $display("FAIL kill_%0d_%0d got edge=%0d hit=%b r=%0d c=%0d s=%0d n=%0d want edge=%0d s=%0d n=%0d",
                             r, c, e, bus.BulletHit, bus.HitRow, bus.HitCol, bus.ScoreInc, AliveCount,
                             c + r + 3, sc, 49 - (r * 10 + c));
                end
            end
        end
        total++; if (AllDead !== 1'b1 || AliveCount !== 6'd0 || AliveMask !== 50'd0)
            begin bad++; $display("FAIL all_dead got dead=%b count=%0d mask=%h want 1/0/0", AllDead, AliveCount, AliveMask); end
        pulse_wave();
        total++; if (AllDead !== 1'b0 || AliveCount !== 6'd50 || AliveMask !== {50{1'b1}})
            begin bad++; $display("FAIL wave_rearm got dead=%b count=%0d mask=%h want 0/50/all ones", AllDead, AliveCount, AliveMask); end
    endtask

    task automatic test_wave_abort();
        int e;
        bit seen;
        shoot(9'd2, 10'd13, e);  // kill (0,0) so the re-arm is observable
        @(negedge Clk);
        bus.BulletValid = 1'b1; bus.BulletRow = 9'd27; bus.BulletCol = 10'd93;
        @(posedge Clk);
        @(negedge Clk); bus.BulletValid = 1'b0;
        @(posedge Clk);
        @(negedge Clk); WaveReset = 1'b1;
        @(posedge Clk); #1;
        total++; if (bus.Busy !== 1'b0 || bus.BulletDone !== 1'b0 || AliveMask !== {50{1'b1}} || AliveCount !== 6'd50)
            begin bad++; $display("FAIL wave_divcol got busy=%b done=%b count=%0d want 0/0/50", bus.Busy, bus.BulletDone, AliveCount); end
        @(negedge Clk); WaveReset = 1'b0;
        seen = 0;
        repeat (15) begin @(posedge Clk); #1; if (bus.BulletDone) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL wave_divcol_nodone got done seen=%b want 0", seen); end

        // Abort in the RESOLVE cycle of a would-be hit on (1,2).
        @(negedge Clk);
        bus.BulletValid = 1'b1; bus.BulletRow = 9'd27; bus.BulletCol = 10'd93;
        @(posedge Clk);
        @(negedge Clk); bus.BulletValid = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk); WaveReset = 1'b1;
        @(posedge Clk); #1;
        total++; if (bus.Busy !== 1'b0 || bus.BulletDone !== 1'b0 || bus.BulletHit !== 1'b0 ||
                     AliveMask !== {50{1'b1}} || AliveCount !== 6'd50)
            begin bad++; $display("FAIL wave_resolve got busy=%b done=%b hit=%b count=%0d want 0/0/0/50",
                                  bus.Busy, bus.BulletDone, bus.BulletHit, AliveCount); end
        @(negedge Clk); WaveReset = 1'b0;
        seen = 0;
        repeat (15) begin @(posedge Clk); #1; if (bus.BulletDone) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL wave_resolve_nodone got done seen=%b want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int e;
        bit seen;
        shoot(9'd2, 10'd13, e);
        @(negedge Clk);
        bus.BulletValid = 1'b1; bus.BulletRow = 9'd27; bus.BulletCol = 10'd93;
        @(posedge Clk);
        @(negedge Clk); bus.BulletValid = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        total++; if (AliveMask !== {50{1'b1}} || AliveCount !== 6'd50 || AllDead !== 1'b0 || bus.Busy !== 1'b0 ||
                     bus.BulletDone !== 1'b0 || bus.BulletHit !== 1'b0 || bus.HitRow !== 3'd0 || bus.HitCol !== 4'd0 ||
                     bus.ScoreInc !== 6'd0)
            begin bad++; $display("FAIL reset_mid got count=%0d busy=%b done=%b hit=%b r=%0d c=%0d s=%0d want reset values",
                                  AliveCount, bus.Busy, bus.BulletDone, bus.BulletHit, bus.HitRow, bus.HitCol, bus.ScoreInc); end
        @(negedge Clk); Reset = 1'b0;
        seen = 0;
        repeat (15) begin @(posedge Clk); #1; if (bus.BulletDone) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_nodone got done seen=%b want 0", seen); end
    endtask

    task automatic test_ignore_and_origin();
        int e;
        AliensRow = 9'd0; AliensCol = 10'd10;
        @(negedge Clk);
        bus.BulletValid = 1'b1; bus.BulletRow = 9'd27; bus.BulletCol = 10'd93;
        @(posedge Clk);
        e = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            bus.BulletValid = n[0]; bus.BulletRow = 9'd2; bus.BulletCol = 10'd13;
            AliensCol = 10'd50;
            @(posedge Clk); #1;
            if (bus.BulletDone) begin e = n; break; end
        end
        total++; if (e !== 6 || bus.BulletHit !== 1'b1 || bus.HitRow !== 3'd1 || bus.HitCol !== 4'd2)
            begin bad++; $display("FAIL captured_origin got edge=%0d hit=%b r=%0d c=%0d want 6/1/1/2", e, bus.BulletHit, bus.HitRow, bus.HitCol); end
        @(negedge Clk); bus.BulletValid = 1'b0; AliensCol = 10'd10;
        repeat (20) @(posedge Clk);
        #1;
        total++; if (AliveMask[0] !== 1'b1 || AliveCount !== 6'd49 || bus.Busy !== 1'b0)
            begin bad++; $display("FAIL ignored_requests got bit0=%b count=%0d busy=%b want 1/49/0", AliveMask[0], AliveCount, bus.Busy); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_dead_and_negative();
        test_gap_overflow();
        test_kill_all();
        test_wave_abort();
        test_reset_mid();
        test_ignore_and_origin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alien_hit_detector.md
# alien_hit_detector

Downstream consumer of the alien formation mover. Holds the alive/dead state of every alien in the 5-row × 10-column formation and resolves each player bullet against the formation origin (AliensRow/AliensCol). Per bullet, it reports hit or miss, the struck cell and a score increment. It also exports the alive mask, which the renderer uses to blank dead aliens. Index resolution is a multi-cycle iterative-subtraction FSM, so no divider is needed.

## Interface
- CellW, 39: horizontal cell pitch in pixels (10 × 39 = 390, the formation width)
- CellH, 24: vertical cell pitch in pixels
- SpriteW, 30: hittable sprite width from the cell's left edge
- SpriteH, 16: hittable sprite height from the cell's top edge
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high; clears all state to reset values
- AliensRow  in  9  formation origin row (top edge of row 0)
- AliensCol  in  10  formation origin column (left edge of col 0)
- WaveReset  in  1  synchronous re-arm of all 50 aliens for a new wave
- BulletValid  in  1  bullet check request; sampled only when Busy=0
- BulletRow  in  9  bullet tip row
- BulletCol  in  10  bullet tip column
- Busy  out  1  check in progress; requests ignored while high
- BulletDone  out  1  one-cycle pulse: check finished
- BulletHit  out  1  one-cycle pulse, coincident with BulletDone, when an alien was killed
- HitRow  out  3  row index of killed alien, valid with BulletHit
- HitCol  out  4  column index of killed alien, valid with BulletHit
- ScoreInc  out  6  points for the kill (row 0: 30; rows 1–2: 20; rows 3–4: 10); 0 when BulletHit=0
- AliveMask  out  50  bit r*10+c = alien (r,c) alive
- AliveCount  out  6  number of live aliens
- AllDead  out  1  AliveCount == 0

## Operation
- Reset values: AliveMask all ones, AliveCount=50, AllDead=0, Busy=0, BulletDone=0, BulletHit=0, HitRow=0, HitCol=0, ScoreInc=0, state IDLE.
- States: IDLE, DIV_COL, DIV_ROW, RESOLVE.
- IDLE, when BulletValid=1:
  - Capture dx = BulletCol − AliensCol (11-bit signed) and dy = BulletRow − AliensRow (10-bit signed).
  - Clear the col/row counters and set Busy.
  - If dx<0 or dy<0, set miss and go to RESOLVE; otherwise go to DIV_COL.
  - Origin motion after capture has no effect on the check.
- DIV_COL, each cycle:
  - If dx ≥ CellW and col=9: set miss and go to RESOLVE.
  - Else if dx ≥ CellW: dx −= CellW, col++.
  - Else go to DIV_ROW.
- DIV_ROW: same procedure with dy, CellH and row limit 4.
- RESOLVE:
  - Hit when !miss, dx < SpriteW, dy < SpriteH and AliveMask[row*10+col]=1.
  - On hit: clear that bit, decrement AliveCount, pulse BulletHit, load HitRow/HitCol/ScoreInc.
  - In all cases: pulse BulletDone, drop Busy, return to IDLE.
- A bullet in a gap between sprites, or on a dead alien, is a miss. The bit is not cleared and AliveCount is unchanged.
- WaveReset (when Reset=0):
  - Sets AliveMask to all ones and AliveCount to 50.
  - Aborts any check: returns to IDLE with Busy=0 and no BulletDone for that check.
  - Takes priority over a same-cycle RESOLVE kill and over a same-cycle BulletValid.
- Reset takes priority over everything.
- Reset or WaveReset mid-check: the aborted check never produces a BulletDone.

## Timing
- Edge 0 samples BulletValid in IDLE; Busy is high from edge 0.
- Non-negative, in-range bullet resolving to column c and row r:
  - DIV_COL occupies c+1 cycles.
  - DIV_ROW occupies r+1 cycles.
  - RESOLVE is 1 cycle.
  - BulletDone/BulletHit rise at edge c+r+3, Busy falls at the same edge, and the next request can be accepted at edge c+r+4.
  - Worst case: 16 cycles.
- Negative dx or dy: BulletDone at edge 1.
- Column overflow: BulletDone at edge 11.
- Row overflow: BulletDone at edge c+7.
- AliveMask, AliveCount and AllDead update at the same edge as BulletHit.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Origin (0,10), bullet (27,93) → col 2 / row 1 hit: BulletHit=1 and BulletDone=1 at edge 6, HitRow=1, HitCol=2, ScoreInc=20, AliveMask bit 12 cleared, AliveCount=49.
- Repeat the same bullet → BulletDone at edge 6 with BulletHit=0, ScoreInc=0, AliveCount still 49. Bullets at (3,5) and (5,10) → miss, BulletDone at edge 1.
- Origin (0,10), bullet (5,45), i.e. dx=35 in the sprite gap → miss at edge 3. Bullet (5,400), i.e. dx=390 → column overflow miss at edge 11. Bullet (130,10), i.e. dy=130 → row overflow miss at edge 7.
- Kill all 50 aliens in sequence (row 0 gives ScoreInc=30, row 4 gives 10) → AllDead=1 and AliveCount=0 after the 50th BulletHit. Then WaveReset → AliveMask all ones, AliveCount=50, AllDead=0.
- WaveReset asserted during DIV_COL, and separately in the RESOLVE cycle of a hit → no BulletDone/BulletHit, Busy=0 next cycle, mask all ones. Reset mid-check → all outputs at reset values.
- Toggle BulletValid while Busy=1 and change AliensCol mid-check → extra requests ignored, and the result matches the origin captured at edge 0.
